// File: rtl/boot_readmemh_parser.sv
// Boot-loader front end: turns a readmemh-style hex character stream into (address, word) writes.
// Optional '//' line comments are compiled in with `define BOOT_READMEMH_COMMENTS_EN.
module boot_readmemh_parser #(
  parameter int unsigned address_width      = 32,
  parameter int unsigned data_width         = 32,
  parameter int unsigned char_width         = 8,
  parameter int unsigned clk_frequency      = 50000000,
  parameter int unsigned timeout_in_seconds = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [char_width-1:0]    in_char,
  output logic                     out_valid,
  output logic [address_width-1:0] out_address,
  output logic [data_width-1:0]    out_data,
  output logic [address_width-1:0] word_count,
  output logic                     busy,
  output logic                     error
);

  localparam int unsigned DATA_DIGITS = data_width / 4;
  localparam int unsigned ADDR_DIGITS = address_width / 4;
  localparam int unsigned MAX_DIGITS  = (DATA_DIGITS > ADDR_DIGITS) ? DATA_DIGITS : ADDR_DIGITS;
  localparam int unsigned ACC_W       = MAX_DIGITS * 4;
  localparam int unsigned DIG_W       = $clog2(MAX_DIGITS + 1);
  localparam int unsigned T_CYCLES    = clk_frequency * timeout_in_seconds;
  localparam int unsigned CNT_W       = $clog2(T_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_ADDR    = 3'd2,
    S_ERR     = 3'd3
`ifdef BOOT_READMEMH_COMMENTS_EN
    ,
    S_SLASH   = 3'd4,
    S_COMMENT = 3'd5
`endif
  } state_t;

  typedef enum logic [2:0] {
    CC_HEX     = 3'd0,
    CC_DELIM   = 3'd1,
    CC_AT      = 3'd2,
    CC_SLASH   = 3'd3,
    CC_ILLEGAL = 3'd4
  } char_class_t;

  function automatic char_class_t classify(input logic [char_width-1:0] c);
    char_class_t k;
    if (c >= char_width'(8'h30) && c <= char_width'(8'h39)) begin
      k = CC_HEX;
    end else if ((c >= char_width'(8'h61) && c <= char_width'(8'h66)) ||
                 (c >= char_width'(8'h41) && c <= char_width'(8'h46))) begin
      k = CC_HEX;
    end else if (c == char_width'(8'h20) || c == char_width'(8'h09) ||
                 c == char_width'(8'h0D) || c == char_width'(8'h0A)) begin
      k = CC_DELIM;
    end else if (c == char_width'(8'h40)) begin
      k = CC_AT;
    end else if (c == char_width'(8'h2F)) begin
      k = CC_SLASH;
    end else begin
      k = CC_ILLEGAL;
    end
    return k;
  endfunction

  // Digits carry their value in the low nibble; letters (either case) sit 9 below theirs.
  function automatic logic [3:0] hex_nibble(input logic [char_width-1:0] c);
    if (c <= char_width'(8'h39)) begin
      return c[3:0];
    end else begin
      return c[3:0] + 4'd9;
    end
  endfunction

  state_t                   state, state_next;
  logic [ACC_W-1:0]         acc, acc_next;
  logic [DIG_W-1:0]         digits, digits_next;
  logic [CNT_W-1:0]         cnt, cnt_next;
  logic                     out_valid_next;
  logic [address_width-1:0] out_address_next;
  logic [data_width-1:0]    out_data_next;
  logic [address_width-1:0] word_count_next;
  logic                     error_next;
  logic                     busy_next;
  char_class_t              cls;
  logic [3:0]               nib;

  // Next-state, datapath and output computation for one character (or idle cycle).
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    digits_next      = digits;
    cnt_next         = cnt;
    out_valid_next   = 1'b0;
    out_data_next    = out_data;
    out_address_next = out_address;
    word_count_next  = word_count;
    error_next       = error;
    cls              = classify(in_char);
    nib              = hex_nibble(in_char);

    if (in_valid) begin
      cnt_next = CNT_W'(T_CYCLES);
    end else if (cnt != CNT_W'(0)) begin
      cnt_next = cnt - CNT_W'(1);
    end else begin
      cnt_next = cnt;
    end

    // Address/count advance the cycle after a word is presented.
    if (out_valid) begin
      out_address_next = out_address + address_width'(1);
      word_count_next  = word_count + address_width'(1);
    end else begin
      out_address_next = out_address;
      word_count_next  = word_count;
    end

    if (in_valid && cnt == CNT_W'(0)) begin
      out_address_next = '0;
      word_count_next  = '0;
      error_next       = 1'b0;
    end else begin
      error_next = error;
    end

    if (in_valid) begin
      case (state)
        S_IDLE: begin
          case (cls)
            CC_HEX: begin
              state_next  = S_DATA;
              acc_next    = ACC_W'(nib);
              digits_next = DIG_W'(1);
            end
            CC_AT: begin
              state_next  = S_ADDR;
              acc_next    = '0;
              digits_next = DIG_W'(0);
            end
            CC_DELIM: state_next = S_IDLE;
`ifdef BOOT_READMEMH_COMMENTS_EN
            CC_SLASH: state_next = S_SLASH;
`endif
            default: begin
              state_next = S_ERR;
              error_next = 1'b1;
            end
          endcase
        end
        S_DATA: begin
          case (cls)
            CC_HEX: begin
              if (digits == DIG_W'(DATA_DIGITS)) begin
                state_next = S_ERR;
                error_next = 1'b1;
              end else begin
                acc_next    = {acc[ACC_W-5:0], nib};
                digits_next = digits + DIG_W'(1);
              end
            end
            CC_DELIM: begin
              state_next     = S_IDLE;
              out_valid_next = 1'b1;
              out_data_next  = acc[data_width-1:0];
            end
            default: begin
              state_next = S_ERR;
              error_next = 1'b1;
            end
          endcase
        end
        S_ADDR: begin
          case (cls)
            CC_HEX: begin
              if (digits == DIG_W'(ADDR_DIGITS)) begin
                state_next = S_ERR;
                error_next = 1'b1;
              end else begin
                acc_next    = {acc[ACC_W-5:0], nib};
                digits_next = digits + DIG_W'(1);
              end
            end
            CC_DELIM: begin
              if (digits == DIG_W'(0)) begin
                state_next = S_ERR;
                error_next = 1'b1;
              end else begin
                state_next       = S_IDLE;
                out_address_next = acc[address_width-1:0];
              end
            end
            default: begin
              state_next = S_ERR;
              error_next = 1'b1;
            end
          endcase
        end
`ifdef BOOT_READMEMH_COMMENTS_EN
        S_SLASH: begin
          if (cls == CC_SLASH) begin
            state_next = S_COMMENT;
          end else begin
            state_next = S_ERR;
            error_next = 1'b1;
          end
        end
        S_COMMENT: begin
          if (in_char == char_width'(8'h0A)) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_COMMENT;
          end
        end
`endif
        S_ERR:   state_next = S_ERR;
        default: state_next = S_IDLE;
      endcase
    end else if (cnt == CNT_W'(1)) begin
      // Session ends: a pending data token is flushed, any other partial is dropped.
      if (state == S_DATA) begin
        out_valid_next = 1'b1;
        out_data_next  = acc[data_width-1:0];
      end else begin
        out_valid_next = 1'b0;
      end
      state_next = S_IDLE;
    end else begin
      state_next = state;
    end

    busy_next = (cnt_next != CNT_W'(0));
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      digits      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_address <= '0;
      word_count  <= '0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      digits      <= digits_next;
      cnt         <= cnt_next;
      out_valid   <= out_valid_next;
      out_data    <= out_data_next;
      out_address <= out_address_next;
      word_count  <= word_count_next;
      error       <= error_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_boot_readmemh_parser.sv
// Directed bench for boot_readmemh_parser with a 16-cycle session timeout.
module tb_boot_readmemh_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        out_valid;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic [31:0] word_count;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cap_n  = 0;
  int base   = 0;
  logic [31:0] cap_addr [0:63];
  logic [31:0] cap_data [0:63];
  logic        ov_fall;

  boot_readmemh_parser #(
    .address_width(32), .data_width(32), .char_width(8),
    .clk_frequency(16), .timeout_in_seconds(1)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .out_valid(out_valid), .out_address(out_address), .out_data(out_data),
    .word_count(word_count), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Record every write strobe as it is presented.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_addr[cap_n % 64] <= out_address;
      cap_data[cap_n % 64] <= out_data;
      cap_n                <= cap_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = s[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(output logic ov);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ov = out_valid;
    #1;
    check_eq("idle_bound", 64'(n < 100), 64'd1);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    settle(2);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_addr",  64'(out_address), 64'd0);
    check_eq("rst_data",  64'(out_data), 64'd0);
    check_eq("rst_wc",    64'(word_count), 64'd0);
    check_eq("rst_busy",  64'(busy), 64'd0);
    check_eq("rst_err",   64'(error), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    settle(1);

    // Full-width word
    base = cap_n;
    send_str("12345678\n");
    settle(3);
    check_eq("t1_count", 64'(cap_n - base), 64'd1);
    check_eq("t1_addr",  64'(cap_addr[base]), 64'd0);
    check_eq("t1_data",  64'(cap_data[base]), 64'h12345678);
    check_eq("t1_wc",    64'(word_count), 64'd1);
    check_eq("t1_busy",  64'(busy), 64'd1);
    wait_idle(ov_fall);
    settle(2);

    // Address directive and short tokens, mixed case
    base = cap_n;
    send_str("@10\nAB cd\n");
    settle(3);
    check_eq("t2_count", 64'(cap_n - base), 64'd2);
    check_eq("t2_addr0", 64'(cap_addr[base]), 64'h10);
    check_eq("t2_data0", 64'(cap_data[base]), 64'hAB);
    check_eq("t2_addr1", 64'(cap_addr[base + 1]), 64'h11);
    check_eq("t2_data1", 64'(cap_data[base + 1]), 64'hCD);
    check_eq("t2_wc",    64'(word_count), 64'd2);
    check_eq("t2_next",  64'(out_address), 64'h12);
    wait_idle(ov_fall);
    settle(2);

    // Too many data digits; error state swallows following chars
    base = cap_n;
    send_str("123456789\n");
    settle(2);
    check_eq("t3_err", 64'(error), 64'd1);
    send_str("5\n");
    settle(3);
    check_eq("t3_count", 64'(cap_n - base), 64'd0);
    wait_idle(ov_fall);
    check_eq("t3_busy", 64'(busy), 64'd0);
    settle(2);

    // New session clears error and address
    base = cap_n;
    send_str("7\n");
    settle(3);
    check_eq("t4_err",   64'(error), 64'd0);
    check_eq("t4_count", 64'(cap_n - base), 64'd1);
    check_eq("t4_addr",  64'(cap_addr[base]), 64'd0);
    check_eq("t4_data",  64'(cap_data[base]), 64'h7);
    check_eq("t4_wc",    64'(word_count), 64'd1);
    send_str("@\n");
    settle(2);
    check_eq("t4_empty_at", 64'(error), 64'd1);
    wait_idle(ov_fall);
    settle(2);

    // Final token flushed by timeout
    base = cap_n;
    send_str("DEADBEEF");
    settle(2);
    check_eq("t5_nowrite", 64'(cap_n - base), 64'd0);
    wait_idle(ov_fall);
    check_eq("t5_ov_fall", 64'(ov_fall), 64'd1);
    settle(1);
    check_eq("t5_count", 64'(cap_n - base), 64'd1);
    check_eq("t5_addr",  64'(cap_addr[base]), 64'd0);
    check_eq("t5_data",  64'(cap_data[base]), 64'hDEADBEEF);
    settle(2);

    // Line comment
    base = cap_n;
    send_str("// x 12\n5\n");
    settle(3);
`ifdef BOOT_READMEMH_COMMENTS_EN
    check_eq("t6_count", 64'(cap_n - base), 64'd1);
    check_eq("t6_addr",  64'(cap_addr[base]), 64'd0);
    check_eq("t6_data",  64'(cap_data[base]), 64'h5);
    check_eq("t6_err",   64'(error), 64'd0);
`else
    check_eq("t6_count", 64'(cap_n - base), 64'd0);
    check_eq("t6_err",   64'(error), 64'd1);
`endif
    wait_idle(ov_fall);
    settle(2);

    // Address wrap at top of space
    base = cap_n;
    send_str("@FFFFFFFF\n1\n2\n");
    settle(3);
    check_eq("t7_count", 64'(cap_n - base), 64'd2);
    check_eq("t7_addr0", 64'(cap_addr[base]), 64'hFFFFFFFF);
    check_eq("t7_addr1", 64'(cap_addr[base + 1]), 64'd0);
    check_eq("t7_data1", 64'(cap_data[base + 1]), 64'h2);
    check_eq("t7_wc",    64'(word_count), 64'd2);
    wait_idle(ov_fall);
    settle(2);

    // TAB and CR delimiters, then reset mid-token
    base = cap_n;
    send_str("F\t2\r");
    settle(3);
    check_eq("t8_count", 64'(cap_n - base), 64'd2);
    check_eq("t8_data0", 64'(cap_data[base]), 64'hF);
    check_eq("t8_addr1", 64'(cap_addr[base + 1]), 64'd1);
    check_eq("t8_data1", 64'(cap_data[base + 1]), 64'h2);
    send_str("ABC");
    reset = 1'b1;
    #1;
    check_eq("t8_rst_busy", 64'(busy), 64'd0);
    check_eq("t8_rst_wc",   64'(word_count), 64'd0);
    check_eq("t8_rst_addr", 64'(out_address), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    base = cap_n;
    send_str("\n");
    wait_idle(ov_fall);
    settle(2);
    check_eq("t8_discard", 64'(cap_n - base), 64'd0);

    // Over-long address
    send_str("@123456789\n");
    settle(2);
    check_eq("t9_addr_len", 64'(error), 64'd1);
    wait_idle(ov_fall);
    settle(2);

    // '@' inside a data token
    base = cap_n;
    send_str("12@");
    settle(2);
    check_eq("t10_at_in_data", 64'(error), 64'd1);
    wait_idle(ov_fall);
    settle(2);
    check_eq("t10_no_flush", 64'(cap_n - base), 64'd0);

    // Illegal character
    send_str("G\n");
    settle(2);
    check_eq("t11_illegal", 64'(error), 64'd1);
    wait_idle(ov_fall);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
